// File: rtl/cam_stream_gen_if.sv
// Parallel camera bus (vsync/href/data) between the stream generator and the
// camera-interface peripheral it feeds.
interface cam_stream_gen_if #(
  parameter int DATA_W = 8
) ();
  logic              vsync;
  logic              href;
  logic [DATA_W-1:0] data;

  modport master (output vsync, output href, output data);
  modport slave  (input  vsync, input  href, input  data);
endinterface

// File: rtl/cam_stream_gen.sv
// Camera-sensor stream generator: emits vsync/href framed pixel bytes from a
// built-in pattern source in RGB565 or RAW8, one byte per clock.
module cam_stream_gen #(
  parameter int HRES        = 640,
  parameter int VRES        = 480,
  parameter int DATA_W      = 8,
  parameter int HBLANK      = 144,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 fmt_i,
  input  logic [1:0]           pattern_i,
  input  logic [23:0]          color_i,
  input  logic [15:0]          num_frames_i,
  cam_stream_gen_if.master     cam_o,
  output logic                 frame_done_o,
  output logic                 busy_o,
  output logic [15:0]          frame_cnt_o
);

  localparam logic [31:0] HRES_W   = 32'(HRES);
  localparam logic [31:0] VRES_W   = 32'(VRES);
  localparam logic [31:0] HBLANK_W = 32'(HBLANK);
  localparam logic [31:0] VSYNC_W  = 32'(VSYNC_LINES);
  localparam logic [31:0] VBP_W    = 32'(VBP_LINES);
  localparam logic [31:0] VFP_W    = 32'(VFP_LINES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VSYNC = 3'd1,
    ST_VBP   = 3'd2,
    ST_LINE  = 3'd3,
    ST_HBL   = 3'd4,
    ST_VFP   = 3'd5
  } state_t;

  function automatic logic [23:0] pattern_rgb(input logic [1:0]  pat,
                                              input logic [31:0] col,
                                              input logic [7:0]  line,
                                              input logic [7:0]  frame,
                                              input logic [23:0] solid);
    logic [31:0] bar;
    logic [23:0] rgb;
    bar = (col * 32'd8) / HRES_W;
    case (pat)
      2'd0: rgb = {col[7:0], line, frame};
      2'd1: begin
        case (bar)
          32'd0:   rgb = 24'hFFFFFF;
          32'd1:   rgb = 24'hFFFF00;
          32'd2:   rgb = 24'h00FFFF;
          32'd3:   rgb = 24'h00FF00;
          32'd4:   rgb = 24'hFF00FF;
          32'd5:   rgb = 24'hFF0000;
          32'd6:   rgb = 24'h0000FF;
          default: rgb = 24'h000000;
        endcase
      end
      2'd2:    rgb = (col[3] ^ line[3]) ? 24'hFFFFFF : 24'h000000;
      2'd3:    rgb = solid;
      default: rgb = 24'h000000;
    endcase
    return rgb;
  endfunction

  // RGB565 splits each pixel as {R5,G3} then {G3,B5}; RAW8 carries green only.
  function automatic logic [7:0] rgb_to_byte(input logic [23:0] rgb,
                                             input logic        raw,
                                             input logic        bsel);
    logic [7:0] b;
    if (raw) begin
      b = rgb[15:8];
    end else if (bsel) begin
      b = {rgb[12:10], rgb[7:3]};
    end else begin
      b = {rgb[23:19], rgb[15:13]};
    end
    return b;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] col_q, col_d;
  logic [31:0] line_q, line_d;
  logic        bsel_q, bsel_d;
  logic        fmt_q, fmt_d;
  logic [1:0]  pattern_q, pattern_d;
  logic [23:0] color_q, color_d;
  logic [15:0] num_q, num_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic              vsync_q, href_q, frame_done_q, busy_q;
  logic [DATA_W-1:0] data_q;

  logic [31:0]       bpl_s, tline_s, vs_len_s, vbp_len_s, vfp_len_s;
  logic [23:0]       rgb_s;
  logic [7:0]        byte_s;
  logic [DATA_W-1:0] data_s;

  // Next-state, phase counters, pixel position and latched configuration.
  always_comb begin
    bpl_s       = fmt_q ? HRES_W : (HRES_W << 1);
    tline_s     = bpl_s + HBLANK_W;
    vs_len_s    = VSYNC_W * tline_s;
    vbp_len_s   = VBP_W * tline_s;
    vfp_len_s   = VFP_W * tline_s;
    state_d     = state_q;
    cnt_d       = cnt_q + 32'd1;
    col_d       = col_q;
    line_d      = line_q;
    bsel_d      = bsel_q;
    fmt_d       = fmt_q;
    pattern_d   = pattern_q;
    color_d     = color_q;
    num_d       = num_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 32'd0;
        if (en_i) begin
          state_d     = ST_VSYNC;
          fmt_d       = fmt_i;
          pattern_d   = pattern_i;
          color_d     = color_i;
          num_d       = num_frames_i;
          frame_cnt_d = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VSYNC: begin
        if (cnt_q == vs_len_s - 32'd1) begin
          state_d = ST_VBP;
          cnt_d   = 32'd0;
        end else begin
          state_d = ST_VSYNC;
        end
      end
      ST_VBP: begin
        if (cnt_q == vbp_len_s - 32'd1) begin
          state_d = ST_LINE;
          cnt_d   = 32'd0;
          col_d   = 32'd0;
          line_d  = 32'd0;
          bsel_d  = 1'b0;
        end else begin
          state_d = ST_VBP;
        end
      end
      ST_LINE: begin
        if (cnt_q == bpl_s - 32'd1) begin
          state_d = ST_HBL;
          cnt_d   = 32'd0;
        end else if (fmt_q || bsel_q) begin
          col_d  = col_q + 32'd1;
          bsel_d = 1'b0;
        end else begin
          bsel_d = 1'b1;
        end
      end
      ST_HBL: begin
        if (cnt_q == HBLANK_W - 32'd1) begin
          cnt_d  = 32'd0;
          col_d  = 32'd0;
          bsel_d = 1'b0;
          if (line_q < VRES_W - 32'd1) begin
            line_d  = line_q + 32'd1;
            state_d = ST_LINE;
          end else begin
            state_d = ST_VFP;
          end
        end else begin
          state_d = ST_HBL;
        end
      end
      ST_VFP: begin
        if (cnt_q == vfp_len_s - 32'd1) begin
          cnt_d       = 32'd0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          if ((num_q != 16'd0) && (frame_cnt_q + 16'd1 == num_q)) begin
            state_d = ST_IDLE;
          end else if (!en_i) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_VSYNC;
            fmt_d     = fmt_i;
            pattern_d = pattern_i;
            color_d   = color_i;
            num_d     = num_frames_i;
          end
        end else begin
          state_d = ST_VFP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 32'd0;
      end
    endcase

    // Data is built from the next position so it lines up with the registered href.
    rgb_s  = pattern_rgb(pattern_d, col_d, line_d[7:0], frame_cnt_d[7:0], color_d);
    byte_s = rgb_to_byte(rgb_s, fmt_d, bsel_d);
    data_s = DATA_W'(byte_s) << (DATA_W - 8);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 32'd0;
      col_q        <= 32'd0;
      line_q       <= 32'd0;
      bsel_q       <= 1'b0;
      fmt_q        <= 1'b0;
      pattern_q    <= 2'd0;
      color_q      <= 24'd0;
      num_q        <= 16'd0;
      frame_cnt_q  <= 16'd0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      line_q       <= line_d;
      bsel_q       <= bsel_d;
      fmt_q        <= fmt_d;
      pattern_q    <= pattern_d;
      color_q      <= color_d;
      num_q        <= num_d;
      frame_cnt_q  <= frame_cnt_d;
      vsync_q      <= (state_d == ST_VSYNC);
      href_q       <= (state_d == ST_LINE);
      data_q       <= (state_d == ST_LINE) ? data_s : '0;
      frame_done_q <= (state_d == ST_VFP) && (cnt_d == vfp_len_s - 32'd1);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign cam_o.vsync  = vsync_q;
  assign cam_o.href   = href_q;
  assign cam_o.data   = data_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = busy_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Directed bench for cam_stream_gen on a tiny 4x2 frame: table of whole-frame
// vectors plus hand sequences for continuous streaming and mid-line reset.
module tb_cam_stream_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        fmt;
  logic [1:0]  pattern;
  logic [23:0] color;
  logic [15:0] num_frames;
  logic        frame_done;
  logic        busy;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_err = 0;

  cam_stream_gen_if #(.DATA_W(8)) cam_bus ();

  cam_stream_gen #(
    .HRES(4), .VRES(2), .DATA_W(8), .HBLANK(2),
    .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .fmt_i(fmt), .pattern_i(pattern),
    .color_i(color), .num_frames_i(num_frames), .cam_o(cam_bus),
    .frame_done_o(frame_done), .busy_o(busy), .frame_cnt_o(frame_cnt)
  );

  always #5 clk = ~clk;

  // Line bytes are packed first-byte-leftmost; RAW8 uses only the upper 4 bytes.
  typedef struct packed {
    logic        fmt;
    logic [1:0]  pat;
    logic [23:0] color;
    logic [15:0] nfr;
    logic [63:0] l0;
    logic [63:0] l1;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int bpl, tline, flen, cyc, vs_cnt, hr_cnt, first_href, dn_cnt, bad_idle, pos;
    logic [63:0] ln;
    logic [7:0]  exp_b;
    bpl = v.fmt ? 4 : 8;
    tline = bpl + 2;
    flen = 5 * tline;
    cyc = 0; vs_cnt = 0; hr_cnt = 0; first_href = 0; dn_cnt = 0; bad_idle = 0;
    fmt = v.fmt; pattern = v.pat; color = v.color; num_frames = v.nfr;
    en = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      cyc++;
      if (!busy) break;
      if (cam_bus.vsync) vs_cnt++;
      if (cam_bus.href) begin
        if (first_href == 0) first_href = cyc;
        pos = hr_cnt % (2 * bpl);
        ln = (pos < bpl) ? v.l0 : v.l1;
        ln = ln >> (8 * (7 - (pos % bpl)));
        exp_b = ln[7:0];
        chk($sformatf("v%0d data[%0d]", id, hr_cnt), 32'(cam_bus.data), 32'(exp_b));
        hr_cnt++;
      end else if (cam_bus.data != 8'h00) begin
        bad_idle++;
      end
      if (frame_done) begin
        dn_cnt++;
        chk($sformatf("v%0d done_cycle", id), 32'(cyc), 32'(dn_cnt * flen));
      end
    end
    en = 1'b0;
    chk($sformatf("v%0d busy_end", id), 32'(busy), 32'd0);
    chk($sformatf("v%0d frame_len", id), 32'(cyc - 1), 32'(int'(v.nfr) * flen));
    chk($sformatf("v%0d vsync_cycles", id), 32'(vs_cnt), 32'(int'(v.nfr) * tline));
    chk($sformatf("v%0d href_cycles", id), 32'(hr_cnt), 32'(int'(v.nfr) * 2 * bpl));
    chk($sformatf("v%0d first_href", id), 32'(first_href), 32'(2 * tline + 1));
    chk($sformatf("v%0d done_count", id), 32'(dn_cnt), 32'(v.nfr));
    chk($sformatf("v%0d idle_data", id), 32'(bad_idle), 32'd0);
    chk($sformatf("v%0d frame_cnt", id), 32'(frame_cnt), 32'(v.nfr));
  endtask

  initial begin
    int cyc, vs_late;
    vecs[0] = '{fmt:1'b0, pat:2'd3, color:24'hFF8040, nfr:16'd1,
                l0:64'hFC08_FC08_FC08_FC08, l1:64'hFC08_FC08_FC08_FC08};
    vecs[1] = '{fmt:1'b1, pat:2'd3, color:24'hFF8040, nfr:16'd1,
                l0:64'h8080_8080_0000_0000, l1:64'h8080_8080_0000_0000};
    vecs[2] = '{fmt:1'b1, pat:2'd0, color:24'h000000, nfr:16'd2,
                l0:64'h0000_0000_0000_0000, l1:64'h0101_0101_0000_0000};
    vecs[3] = '{fmt:1'b0, pat:2'd1, color:24'h000000, nfr:16'd1,
                l0:64'hFFFF_07FF_F81F_001F, l1:64'hFFFF_07FF_F81F_001F};
    vecs[4] = '{fmt:1'b1, pat:2'd1, color:24'h000000, nfr:16'd1,
                l0:64'hFFFF_0000_0000_0000, l1:64'hFFFF_0000_0000_0000};
    vecs[5] = '{fmt:1'b0, pat:2'd3, color:24'h123456, nfr:16'd1,
                l0:64'h11AA_11AA_11AA_11AA, l1:64'h11AA_11AA_11AA_11AA};
    vecs[6] = '{fmt:1'b1, pat:2'd2, color:24'hFFFFFF, nfr:16'd1,
                l0:64'h0000_0000_0000_0000, l1:64'h0000_0000_0000_0000};

    rst = 1'b1; en = 1'b1; fmt = 1'b0; pattern = 2'd3; color = 24'hFFFFFF;
    num_frames = 16'd1;
    repeat (2) @(negedge clk);
    chk("rst vsync", 32'(cam_bus.vsync), 32'd0);
    chk("rst href", 32'(cam_bus.href), 32'd0);
    chk("rst data", 32'(cam_bus.data), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(frame_done), 32'd0);
    chk("rst frame_cnt", 32'(frame_cnt), 32'd0);
    en = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Continuous stream: second frame follows directly, en dropped in its line 0.
    fmt = 1'b0; pattern = 2'd3; color = 24'hFF8040; num_frames = 16'd0; en = 1'b1;
    vs_late = 0;
    for (cyc = 1; cyc <= 121; cyc++) begin
      @(negedge clk);
      if (cyc == 50) chk("cont done f1", 32'(frame_done), 32'd1);
      if (cyc == 51) begin
        chk("cont vsync f2", 32'(cam_bus.vsync), 32'd1);
        chk("cont busy f2", 32'(busy), 32'd1);
        chk("cont done width", 32'(frame_done), 32'd0);
        chk("cont cnt f1", 32'(frame_cnt), 32'd1);
      end
      if (cyc == 72) begin
        chk("cont href f2", 32'(cam_bus.href), 32'd1);
        en = 1'b0;
      end
      if (cyc == 100) begin
        chk("drop done", 32'(frame_done), 32'd1);
        chk("drop busy at done", 32'(busy), 32'd1);
      end
      if (cyc == 101) begin
        chk("drop busy after", 32'(busy), 32'd0);
        chk("drop cnt", 32'(frame_cnt), 32'd2);
      end
      if (cyc > 101 && (cam_bus.vsync || busy)) vs_late++;
    end
    chk("drop no restart", 32'(vs_late), 32'd0);

    // Asynchronous reset in the middle of an active line.
    en = 1'b1; num_frames = 16'd0;
    for (cyc = 1; cyc <= 25; cyc++) @(negedge clk);
    chk("pre-rst href", 32'(cam_bus.href), 32'd1);
    chk("pre-rst data", 32'(cam_bus.data), 32'hFC);
    #2 rst = 1'b1;
    #1;
    chk("async href", 32'(cam_bus.href), 32'd0);
    chk("async vsync", 32'(cam_bus.vsync), 32'd0);
    chk("async data", 32'(cam_bus.data), 32'd0);
    chk("async busy", 32'(busy), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post-rst vsync", 32'(cam_bus.vsync), 32'd1);
    chk("post-rst busy", 32'(busy), 32'd1);
    chk("post-rst cnt", 32'(frame_cnt), 32'd0);
    en = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("final idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
